// File: rtl/adder_pkg.sv
// Shared encodings for the adder controller: FSM state codes and the
// datapath accumulate-select values.
package adder_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LOAD   = 3'd1;
    localparam state_t S_ADD_AB = 3'd2;
    localparam state_t S_ADD_C  = 3'd3;
    localparam state_t S_ADD_D  = 3'd4;
    localparam state_t S_OUT    = 3'd5;
    localparam state_t S_DONE   = 3'd6;

    localparam logic [1:0] BSEL_AB  = 2'b00;
    localparam logic [1:0] BSEL_C   = 2'b01;
    localparam logic [1:0] BSEL_D   = 2'b10;
    localparam logic [1:0] BSEL_NOP = 2'b11;

    // A run is cancellable only while the datapath is actually working.
    function automatic logic is_run_state(input state_t s);
        return (s != S_IDLE) && (s != S_DONE);
    endfunction

endpackage

// File: rtl/adder_controller.sv
// Sequencing controller for a 2-to-4 operand adder datapath.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for start; start+abort together ignored
// LOAD     | strobe all four operand registers
// ADD_AB   | acc = A + B
// ADD_C    | acc += C (latched n_ops >= 1)
// ADD_D    | acc += D (latched n_ops >= 2)
// OUT      | transfer accumulator to datapath output
// DONE     | one-cycle completion; run counter bumps here
module adder_controller
    import adder_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         n_ops,
    input  logic               abort,
    output logic               aload,
    output logic               bload,
    output logic               cload,
    output logic               dload,
    output logic               asel,
    output logic [1:0]         bsel,
    output logic               output_enable,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [COUNT_W-1:0] run_count
);

    state_t             state_q, state_d;
    logic [1:0]         nops_q, nops_d;
    logic               aborted_q, aborted_d;
    logic [COUNT_W-1:0] count_q;

    // State, latched operand count and abort pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            nops_q    <= 2'd0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nops_q    <= nops_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state logic; n_ops is captured only on the launching edge,
    // with code 3 folded onto 2 so later compares stay simple.
    always_comb begin
        state_d   = state_q;
        nops_d    = nops_q;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_LOAD;
                    nops_d  = (n_ops == 2'd3) ? 2'd2 : n_ops;
                end
            end
            S_LOAD:   state_d = S_ADD_AB;
            S_ADD_AB: state_d = (nops_q >= 2'd1) ? S_ADD_C : S_OUT;
            S_ADD_C:  state_d = (nops_q >= 2'd2) ? S_ADD_D : S_OUT;
            S_ADD_D:  state_d = S_OUT;
            S_OUT:    state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (is_run_state(state_q) && abort) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end
    end

    // Moore decode of datapath controls: one action per state.
    always_comb begin
        aload         = 1'b0;
        bload         = 1'b0;
        cload         = 1'b0;
        dload         = 1'b0;
        asel          = 1'b0;
        bsel          = BSEL_NOP;
        output_enable = 1'b0;
        case (state_q)
            S_LOAD: begin
                aload = 1'b1;
                bload = 1'b1;
                cload = 1'b1;
                dload = 1'b1;
            end
            S_ADD_AB: begin
                asel = 1'b1;
                bsel = BSEL_AB;
            end
            S_ADD_C:  bsel = BSEL_C;
            S_ADD_D:  bsel = BSEL_D;
            S_OUT:    output_enable = 1'b1;
            default:  ;
        endcase
    end

    // Completed-run counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if ((state_q == S_DONE) && (count_q != {COUNT_W{1'b1}})) begin
            count_q <= count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign aborted   = aborted_q;
    assign run_count = count_q;

endmodule

// File: tb/tb_adder_controller.sv
// Bench for adder_controller: a behavioural datapath driven by the
// controller's strobes, a scoreboard of expected sums popped on done,
// and per-scenario tasks checking the control sequence cycle by cycle.
module tb_adder_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] n_ops = 2'd0;
    logic       abort = 1'b0;
    logic       aload, bload, cload, dload, asel, output_enable;
    logic       busy, done, aborted;
    logic [1:0] bsel;
    logic [1:0] run_count;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    logic [7:0] sum_q[$];

    logic [7:0] op_a = 8'd0, op_b = 8'd0, op_c = 8'd0, op_d = 8'd0;
    logic [7:0] ra = 8'd0, rb = 8'd0, rc = 8'd0, rd = 8'd0;
    logic [7:0] acc = 8'd0, o_sum = 8'd0;

    // {aload,bload,cload,dload,asel,bsel,output_enable}
    localparam logic [7:0] C_IDLE = 8'b0000_0110;
    localparam logic [7:0] C_LOAD = 8'b1111_0110;
    localparam logic [7:0] C_AB   = 8'b0000_1000;
    localparam logic [7:0] C_C    = 8'b0000_0010;
    localparam logic [7:0] C_D    = 8'b0000_0100;
    localparam logic [7:0] C_OUT  = 8'b0000_0111;

    adder_controller #(.COUNT_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .n_ops(n_ops), .abort(abort),
        .aload(aload), .bload(bload), .cload(cload), .dload(dload),
        .asel(asel), .bsel(bsel), .output_enable(output_enable),
        .busy(busy), .done(done), .aborted(aborted), .run_count(run_count)
    );

    always #5 clk = ~clk;

    // Behavioural datapath obeying the controller strobes.
    always @(posedge clk) begin
        if (aload) ra <= op_a;
        if (bload) rb <= op_b;
        if (cload) rc <= op_c;
        if (dload) rd <= op_d;
        if (asel) acc <= ra + rb;
        else if (bsel == 2'b01) acc <= acc + rc;
        else if (bsel == 2'b10) acc <= acc + rd;
        if (output_enable) o_sum <= acc;
    end

    // Scoreboard: every done pulse must match an outstanding expected sum.
    always @(negedge clk) begin
        if (rst && done) begin
            done_cnt++;
            total++;
            if (sum_q.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected: o_sum=%0d with no run outstanding", o_sum);
            end else begin
                logic [7:0] e;
                e = sum_q.pop_front();
                if (o_sum !== e) begin
                    bad++;
                    $display("FAIL sum: got %0d expected %0d", o_sum, e);
                end
            end
        end
    end

    function automatic logic [10:0] obs();
        return {aload, bload, cload, dload, asel, bsel, output_enable, busy, done, aborted};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #2;
        total++;
        if ({obs(), run_count} !== {C_IDLE, 3'b000, 2'd0}) begin
            bad++;
            $display("FAIL reset: got %b expected %b", {obs(), run_count}, {C_IDLE, 3'b000, 2'd0});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One run; abort_at / restart_at are step indices (-1 = none).
    task automatic run_case(input string name, input logic [1:0] nops,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d,
                            input int abort_at, input int restart_at);
        logic [7:0] seq[$];
        logic [7:0] es;
        logic [10:0] exp_w;
        int n;
        bit cut;
        seq = {C_LOAD, C_AB};
        es = a + b;
        if (nops >= 2'd1) begin seq.push_back(C_C); es = es + c; end
        if (nops >= 2'd2) begin seq.push_back(C_D); es = es + d; end
        seq.push_back(C_OUT);
        seq.push_back(C_IDLE);
        n = seq.size();
        cut = 1'b0;
        @(negedge clk);
        op_a = a; op_b = b; op_c = c; op_d = d;
        n_ops = nops;
        start = 1'b1;
        if (abort_at < 0 || abort_at >= n - 1) sum_q.push_back(es);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            n_ops = 2'($urandom_range(0, 3));
            exp_w = {seq[k], 1'b1, (k == n - 1), 1'b0};
            total++;
            if (obs() !== exp_w) begin
                bad++;
                $display("FAIL %s step%0d: got %b expected %b", name, k, obs(), exp_w);
            end
            if (k == restart_at) start = 1'b1;
            if (k == abort_at) begin
                abort = 1'b1;
                if (k < n - 1) begin
                    cut = 1'b1;
                    break;
                end
            end
        end
        if (cut) begin
            @(negedge clk);
            abort = 1'b0;
            total++;
            if (obs() !== {C_IDLE, 3'b001}) begin
                bad++;
                $display("FAIL %s abort_pulse: got %b expected %b", name, obs(), {C_IDLE, 3'b001});
            end
        end
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        total++;
        if (obs() !== {C_IDLE, 3'b000}) begin
            bad++;
            $display("FAIL %s end_idle: got %b expected %b", name, obs(), {C_IDLE, 3'b000});
        end
    endtask

    task automatic test_count(input string name, input logic [1:0] e);
        total++;
        if (run_count !== e) begin
            bad++;
            $display("FAIL %s run_count: got %0d expected %0d", name, run_count, e);
        end
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        n_ops = 2'd2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (obs() !== {C_IDLE, 3'b000}) begin
                bad++;
                $display("FAIL start_abort_idle c%0d: got %b expected %b", k, obs(), {C_IDLE, 3'b000});
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        op_a = 8'd9; op_b = 8'd9; op_c = 8'd9; op_d = 8'd9;
        n_ops = 2'd2;
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if (obs() !== {C_D, 3'b100}) begin
            bad++;
            $display("FAIL rst_mid in_add_d: got %b expected %b", obs(), {C_D, 3'b100});
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({obs(), run_count} !== {C_IDLE, 3'b000, 2'd0}) begin
            bad++;
            $display("FAIL rst_mid async: got %b expected %b", {obs(), run_count}, {C_IDLE, 3'b000, 2'd0});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (obs() !== {C_IDLE, 3'b000}) begin
                bad++;
                $display("FAIL rst_mid idle_after c%0d: got %b expected %b", k, obs(), {C_IDLE, 3'b000});
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int d0;
        @(negedge clk);
        op_a = 8'd1; op_b = 8'd2; op_c = 8'd50; op_d = 8'd60;
        n_ops = 2'd0;
        start = 1'b1;
        for (int k = 0; k < 5; k++) sum_q.push_back(8'd3);
        d0 = done_cnt;
        pulses = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done) pulses++;
            if (pulses == 5) break;
        end
        start = 1'b0;
        total++;
        if (pulses != 5) begin
            bad++;
            $display("FAIL b2b pulses: got %0d expected 5", pulses);
        end
        for (int k = 0; k < 4; k++) @(negedge clk);
        total++;
        if ({obs(), run_count} !== {C_IDLE, 3'b000, 2'd3}) begin
            bad++;
            $display("FAIL b2b final: got %b expected %b", {obs(), run_count}, {C_IDLE, 3'b000, 2'd3});
        end
        total++;
        if ((done_cnt - d0) != 5 || sum_q.size() != 0) begin
            bad++;
            $display("FAIL b2b scoreboard: done=%0d expected 5, left=%0d expected 0", done_cnt - d0, sum_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_count("reset", 2'd0);
        run_case("n2", 2'd2, 8'd3, 8'd4, 8'd5, 8'd6, 5, -1);
        test_count("n2", 2'd1);
        run_case("n0", 2'd0, 8'd15, 8'd15, 8'd99, 8'd99, -1, -1);
        test_count("n0", 2'd2);
        run_case("abort_c", 2'd1, 8'd7, 8'd8, 8'd9, 8'd10, 2, -1);
        test_count("abort_c", 2'd2);
        run_case("restart_ab", 2'd1, 8'd20, 8'd21, 8'd22, 8'd23, -1, 1);
        test_count("restart_ab", 2'd3);
        test_start_abort_idle();
        test_count("start_abort_idle", 2'd3);
        run_case("n3_sat", 2'd3, 8'd1, 8'd2, 8'd3, 8'd4, -1, -1);
        test_count("n3_sat", 2'd3);
        test_reset_mid_run();
        test_count("rst_mid", 2'd0);
        test_back_to_back();
        total++;
        if (sum_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d outstanding expected 0", sum_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_controller.md
ADDER_CONTROLLER -- requirements
Module: adder_controller

Interface
REQ-001 Parameter: COUNT_W, default 8, width of completed-run counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one summation run; sampled only in IDLE.
REQ-005 n_ops  input  2  operand select: 0 = A+B, 1 = A+B+C, 2 = A+B+C+D, 3 = treated as 2; captured with start.
REQ-006 abort  input  1  cancel run in progress.
REQ-007 aload, bload, cload, dload  output  1 each  operand-register load strobes to datapath.
REQ-008 asel  output  1  datapath A/B add select.
REQ-009 bsel  output  2  datapath accumulate select: 00 = A+B, 01 = +C, 10 = +D, 11 = no-op.
REQ-010 output_enable  output  1  datapath sum-to-output transfer strobe.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on run completion.
REQ-013 aborted  output  1  one-cycle pulse on abort acceptance.
REQ-014 run_count  output  COUNT_W  number of completed runs, saturating.

Function
REQ-015 States SHALL be IDLE, LOAD, ADD_AB, ADD_C, ADD_D, OUT, DONE.
REQ-016 Datapath control outputs SHALL be Moore-decoded from state only; exactly one datapath action per state.
REQ-017 IDLE/DONE: all loads 0, asel 0, bsel 11, output_enable 0.
REQ-018 LOAD: all four loads 1, asel 0, bsel 11, output_enable 0.
REQ-019 ADD_AB: asel 1, bsel 00; ADD_C: asel 0, bsel 01; ADD_D: asel 0, bsel 10; all loads 0 and output_enable 0 in these states.
REQ-020 OUT: output_enable 1, loads 0, asel 0, bsel 11.
REQ-021 IDLE -> LOAD when start=1 and abort=0; n_ops latched on that edge.
REQ-022 LOAD -> ADD_AB; ADD_AB -> ADD_C if latched n_ops >= 1 else OUT; ADD_C -> ADD_D if latched n_ops >= 2 else OUT; ADD_D -> OUT; OUT -> DONE; DONE -> IDLE.
REQ-023 done SHALL be 1 exactly in DONE; latency from start edge to done high: 4 cycles (n_ops 0), 5 (n_ops 1), 6 (n_ops 2/3).
REQ-024 abort=1 in LOAD, ADD_AB, ADD_C, ADD_D or OUT SHALL force IDLE on the next edge, with aborted high for one cycle after, no done, run_count unchanged.
REQ-025 abort in IDLE or DONE SHALL be ignored; DONE completes normally.
REQ-026 start while busy SHALL be ignored (no queueing); start held high through DONE re-launches from IDLE on the following edge.
REQ-027 start and abort both high in IDLE: remain IDLE, no aborted pulse.
REQ-028 run_count SHALL increment on the DONE-state edge, saturating at all-ones.
REQ-029 n_ops changes during a run SHALL not affect that run.

Reset
REQ-030 rst low SHALL immediately force IDLE, latched n_ops 0, done 0, aborted 0, run_count 0, busy 0, control outputs per REQ-017, independent of clk.
REQ-031 Reset mid-run SHALL discard the run; first run after release requires a fresh start.

Structure
REQ-032 State encoding and bsel constants (BSEL_AB, BSEL_C, BSEL_D, BSEL_NOP) SHALL live in shared package adder_pkg.
REQ-033 Single module, no sub-modules; next-state logic, output decode and counter in separate processes.

Verification
REQ-034 n_ops=2, A=3,B=4,C=5,D=6, start pulse -> controls LOAD,AB,C,D,OUT in order, done 6 cycles after start, datapath o_sum=18, run_count=1.
REQ-035 n_ops=0, A=15,B=15 -> ADD_C/ADD_D skipped, done at 4 cycles, o_sum=30.
REQ-036 n_ops=1, abort asserted in ADD_C -> IDLE next edge, aborted one pulse, done never high, run_count unchanged.
REQ-037 start re-pulsed during ADD_AB and start+abort together in IDLE -> no second run, no aborted pulse, state sequence unchanged.
REQ-038 rst low in ADD_D -> all outputs at reset values without clock edge; after release, idle until new start.
REQ-039 COUNT_W=2, five back-to-back runs with start held high -> run_count saturates at 3, done pulses five times.
